// File: rtl/lns_pkg.sv
// rtl/lns_pkg.sv - shared widths, codes, state encodings and antilog constants for the LNS converter
package lns_pkg;
  localparam int LOG_W    = 22;
  localparam int FRAC_W   = 12;
  localparam int LIN_W    = 32;
  localparam int LIN_FRAC = 16;
  localparam int M_W      = 24;
  localparam int INT_W    = LOG_W - FRAC_W;

  localparam logic [LOG_W-1:0] ZERO_CODE = 22'h200000;
  localparam logic [LIN_W-1:0] SAT_POS   = 32'h7FFF_FFFF;
  localparam logic [LIN_W-1:0] SAT_NEG   = 32'h8000_0001;
  localparam logic [M_W-1:0]   M_ONE     = 24'h400000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_MUL   = 2'd1;
  localparam state_t ST_SCALE = 2'd2;
  localparam state_t ST_OUT   = 2'd3;

  // 2^(2^-k) in unsigned Q2.22, rounded to nearest
  localparam logic [M_W-1:0] ANTILOG_C [1:FRAC_W] = '{
    24'h5A827A, 24'h4C1BF8, 24'h45CAE1, 24'h42D562,
    24'h4166C3, 24'h40B269, 24'h4058F7, 24'h402C6C,
    24'h401632, 24'h400B18, 24'h40058C, 24'h4002C6
  };
endpackage

// File: rtl/lns_mul_round.sv
// rtl/lns_mul_round.sv - Q2.22 x Q2.22 unsigned multiply with round-half-up back to Q2.22
module lns_mul_round
  import lns_pkg::*;
(
  input  logic [M_W-1:0] a,
  input  logic [M_W-1:0] b,
  output logic [M_W-1:0] p
);
  localparam logic [2*M_W-1:0] HALF = 48'd1 << (M_W - 3);

  logic [2*M_W-1:0] a_w;
  logic [2*M_W-1:0] b_w;

  always_comb begin
    a_w = {{M_W{1'b0}}, a};
    b_w = {{M_W{1'b0}}, b};
    p   = M_W'((a_w * b_w + HALF) >> (M_W - 2));
  end
endmodule

// File: rtl/lns_to_linear.sv
// rtl/lns_to_linear.sv - sequential LNS (Q9.12 log2 + sign) to Q15.16 linear converter
module lns_to_linear
  import lns_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOG_W-1:0] in_log,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LIN_W-1:0] out_lin,
  output logic             out_sat,
  output logic             out_zero
);
  localparam int SH_W       = INT_W + 1;
  localparam int SHIFT_BIAS = (M_W - 2) - LIN_FRAC;
  localparam int SAT_EXP    = LIN_W - 1 - LIN_FRAC;

  state_t             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [M_W-1:0]     m_q, m_d;
  logic [FRAC_W-1:0]  f_q, f_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic               sign_q, sign_d;
  logic               zcode_q, zcode_d;
  logic               out_valid_q, out_valid_d;
  logic [LIN_W-1:0]   out_lin_q, out_lin_d;
  logic               out_sat_q, out_sat_d;
  logic               out_zero_q, out_zero_d;

  logic [M_W-1:0]     c_k;
  logic [M_W-1:0]     mul_p;
  logic [LIN_W-1:0]   m_ext;
  logic [LIN_W-1:0]   mag;
  logic [LIN_W-1:0]   scaled_lin;
  logic               scaled_sat;
  logic               scaled_zero;
  logic signed [SH_W-1:0] shift_s;
  logic signed [SH_W-1:0] neg_amt;

  assign c_k = ANTILOG_C[k_q];

  lns_mul_round u_mul (
    .a (m_q),
    .b (c_k),
    .p (mul_p)
  );

  // Integer part of the log applied as a shift of the Q2.22 mantissa into Q15.16
  always_comb begin
    m_ext       = {{(LIN_W-M_W){1'b0}}, m_q};
    shift_s     = $signed({int_q[INT_W-1], int_q}) - $signed(SH_W'(SHIFT_BIAS));
    neg_amt     = -shift_s;
    mag         = '0;
    scaled_sat  = 1'b0;
    scaled_zero = 1'b0;
    if (zcode_q) begin
      scaled_zero = 1'b1;
    end else if ($signed(int_q) >= $signed(INT_W'(SAT_EXP))) begin
      mag        = SAT_POS;
      scaled_sat = 1'b1;
    end else if (!shift_s[SH_W-1]) begin
      mag = m_ext << shift_s[3:0];
    end else if (neg_amt > $signed(SH_W'(M_W - 1))) begin
      scaled_zero = 1'b1;
    end else begin
      mag         = (m_ext + (32'd1 << (neg_amt[4:0] - 5'd1))) >> neg_amt[4:0];
      scaled_zero = (mag == '0);
    end
    if (scaled_sat && sign_q) begin
      scaled_lin = SAT_NEG;
    end else if (sign_q) begin
      scaled_lin = -mag;
    end else begin
      scaled_lin = mag;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    m_d         = m_q;
    f_d         = f_q;
    int_d       = int_q;
    sign_d      = sign_q;
    zcode_d     = zcode_q;
    out_valid_d = out_valid_q;
    out_lin_d   = out_lin_q;
    out_sat_d   = out_sat_q;
    out_zero_d  = out_zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          int_d   = in_log[LOG_W-1:FRAC_W];
          f_d     = in_log[FRAC_W-1:0];
          sign_d  = in_sign;
          zcode_d = (in_log == ZERO_CODE);
          m_d     = M_ONE;
          k_d     = 4'd1;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        // f is consumed MSB first so iteration k always sees bit FRAC_W-k
        if (f_q[FRAC_W-1]) begin
          m_d = mul_p;
        end
        f_d = f_q << 1;
        if (k_q == 4'(FRAC_W)) begin
          k_d     = 4'd0;
          state_d = ST_SCALE;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      ST_SCALE: begin
        out_lin_d   = scaled_lin;
        out_sat_d   = scaled_sat;
        out_zero_d  = scaled_zero;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_lin_d   = '0;
          out_sat_d   = 1'b0;
          out_zero_d  = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= 4'd0;
      m_q         <= '0;
      f_q         <= '0;
      int_q       <= '0;
      sign_q      <= 1'b0;
      zcode_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_lin_q   <= '0;
      out_sat_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      m_q         <= m_d;
      f_q         <= f_d;
      int_q       <= int_d;
      sign_q      <= sign_d;
      zcode_q     <= zcode_d;
      out_valid_q <= out_valid_d;
      out_lin_q   <= out_lin_d;
      out_sat_q   <= out_sat_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_lin   = out_lin_q;
  assign out_sat   = out_sat_q;
  assign out_zero  = out_zero_q;
endmodule

// File: tb/tb_lns_to_linear.sv
// tb/tb_lns_to_linear.sv - self-checking bench for lns_to_linear against a real-arithmetic model
module tb_lns_to_linear;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [21:0] in_log = '0;
  logic        in_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_lin;
  logic        out_sat;
  logic        out_zero;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lns_to_linear dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_log    (in_log),
    .in_sign   (in_sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lin   (out_lin),
    .out_sat   (out_sat),
    .out_zero  (out_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left on a falling edge; returns accept-to-out_valid latency and the result
  task automatic convert(input logic [21:0] code, input logic sg, output int lat,
                         output logic [31:0] lin, output logic sat, output logic zr);
    int guard;
    in_log   = code;
    in_sign  = sg;
    in_valid = 1'b1;
    guard    = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    lin = out_lin;
    sat = out_sat;
    zr  = out_zero;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_exact(input string tag, input logic [21:0] code, input logic sg,
                           input logic [31:0] exp_lin, input logic exp_sat, input logic exp_zero);
    int lat;
    logic [31:0] lin;
    logic sat, zr;
    convert(code, sg, lat, lin, sat, zr);
    check({tag, "_latency"}, 32'(lat), 32'd13);
    check({tag, "_lin"}, lin, exp_lin);
    check({tag, "_sat"}, {31'd0, sat}, {31'd0, exp_sat});
    check({tag, "_zero"}, {31'd0, zr}, {31'd0, exp_zero});
  endtask

  // Value = 2^(log/4096) scaled by 2^16; underflow below 2^-17 exponent, saturation from 2^15
  function automatic void model(input logic [21:0] code, input logic sg, output real want,
                                output logic w_sat, output logic w_zero, output real tol);
    int v;
    int ip;
    v      = int'($signed(code));
    ip     = v >>> 12;
    w_sat  = 1'b0;
    w_zero = 1'b0;
    tol    = 0.0;
    want   = 0.0;
    if (code == 22'h200000) begin
      w_zero = 1'b1;
    end else if (ip >= 15) begin
      w_sat = 1'b1;
      want  = sg ? -2147483647.0 : 2147483647.0;
    end else if (ip < -17) begin
      w_zero = 1'b1;
    end else begin
      want = (2.0 ** (real'(v) / 4096.0)) * 65536.0;
      tol  = (ip <= 3) ? 2.0 : 2.0 + want / 262144.0;
      if (sg) want = -want;
    end
  endfunction

  task automatic run_model(input string tag, input logic [21:0] code, input logic sg);
    int lat;
    logic [31:0] lin;
    logic sat, zr, w_sat, w_zero, close;
    real want, tol, got, diff;
    convert(code, sg, lat, lin, sat, zr);
    model(code, sg, want, w_sat, w_zero, tol);
    got   = real'($signed(lin));
    diff  = (got > want) ? got - want : want - got;
    close = (diff <= tol);
    check({tag, "_latency"}, 32'(lat), 32'd13);
    check({tag, "_sat"}, {31'd0, sat}, {31'd0, w_sat});
    check({tag, "_zero"}, {31'd0, zr}, {31'd0, w_zero});
    n_assert++;
    assert (close === 1'b1) else begin
      n_fail++;
      $error("FAIL %s_value: code %h sign %0d observed %0d expected %f within %f", tag, code, sg,
             $signed(lin), want, tol);
    end
  endtask

  initial begin
    int lat;
    int ri;
    int rf;
    logic [31:0] held;
    logic stale;
    logic [21:0] bnd [6];

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_lin", out_lin, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_out_zero", {31'd0, out_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_exact("one", 22'h000000, 1'b0, 32'h0001_0000, 1'b0, 1'b0);
    run_model("sqrt2", 22'h000800, 1'b0);
    run_exact("neg_two", 22'h001000, 1'b1, 32'hFFFE_0000, 1'b0, 1'b0);
    run_exact("sat_pos", 22'h00F000, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_exact("sat_neg", 22'h00F000, 1'b1, 32'h8000_0001, 1'b1, 1'b0);
    run_exact("zero_code", 22'h200000, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    run_exact("zero_code_neg", 22'h200000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
    run_exact("underflow", 22'h3EE000, 1'b0, 32'h0000_0000, 1'b0, 1'b1);
    run_exact("quarter", 22'h3FE000, 1'b1, 32'hFFFF_C000, 1'b0, 1'b0);

    bnd[0] = 22'h3EF000;
    bnd[1] = 22'h3EEFFF;
    bnd[2] = 22'h00EFFF;
    bnd[3] = 22'h006000;
    bnd[4] = 22'h005FFF;
    bnd[5] = 22'h000FFF;
    for (int b = 0; b < 6; b++) begin
      run_model($sformatf("bound%0d", b), bnd[b], b[0]);
    end

    for (int t = 0; t < 24; t++) begin
      ri = int'($urandom_range(36)) - 20;
      rf = int'($urandom_range(4095));
      run_model($sformatf("rand%0d", t), 22'(ri * 4096 + rf), 1'(($urandom_range(1))));
    end

    // Output stall with in_valid held and the input word changing underneath
    in_log    = 22'h001000;
    in_sign   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_log = 22'h002000;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("stall_latency", 32'(lat), 32'd13);
    held = out_lin;
    check("stall_first", held, 32'h0002_0000);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", c), out_lin, held);
      check($sformatf("stall_in_ready%0d", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("stall_valid%0d", c), {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("reaccept_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("second_latency", 32'(lat), 32'd13);
    check("second_lin", out_lin, 32'h0004_0000);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the sixth multiply iteration
    in_log   = 22'h001800;
    in_sign  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_lin", out_lin, 32'd0);
    stale = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("midrst_no_stale", {31'd0, stale}, 32'd0);
    run_exact("after_rst", 22'h002000, 1'b0, 32'h0004_0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
